// File: rtl/hazard_controller.sv
// hazard_controller: load-use stalls, mul/div sequencing and flush control.
// Optional perf counters under `HAZARD_PERF_CNT_EN (tied to 0 otherwise).
module hazard_controller #(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_use_rs1,
  input  logic             ifid_use_rs2,
  input  logic             idex_memrd,
  input  logic [4:0]       idex_rd,
  input  logic             idex_md_req,
  input  logic             branch_taken,
  input  logic             kill,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_bubble,
  output logic             md_start,
  output logic             md_done,
  output logic             md_abort,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [7:0] LAT = 8'(MD_LATENCY);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       load_use;

  assign load_use = idex_memrd && (idex_rd != 5'd0) &&
                    (((idex_rd == ifid_rs1) && ifid_use_rs1) ||
                     ((idex_rd == ifid_rs2) && ifid_use_rs2));

  // state and busy down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state and all pipeline controls; idle values while in reset
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    md_start     = 1'b0;
    md_done      = 1'b0;
    md_abort     = 1'b0;
    md_busy      = 1'b0;
    if (rst_n) begin
      md_busy = (state_q == BUSY);
      if (kill) begin
        ifid_flush   = 1'b1;
        idex_flush   = 1'b1;
        exmem_bubble = 1'b1;
        md_abort     = (state_q != IDLE);
        state_d      = IDLE;
        cnt_d        = 8'd0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (idex_md_req) begin
              md_start     = 1'b1;
              pc_write     = 1'b0;
              ifid_write   = 1'b0;
              idex_write   = 1'b0;
              exmem_bubble = 1'b1;
              state_d      = BUSY;
              cnt_d        = LAT;
            end else if (branch_taken) begin
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
            end else if (load_use) begin
              pc_write   = 1'b0;
              ifid_write = 1'b0;
              idex_flush = 1'b1;
            end
          end
          BUSY: begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            cnt_d        = cnt_q - 8'd1;
            if (cnt_q == 8'd1) begin
              state_d = DONE;
            end
          end
          DONE: begin
            md_done = 1'b1;
            state_d = IDLE;
          end
          default: begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        endcase
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  // wrapping event counts
  always_comb begin
    stall_d = stall_q + CNT_W'(!pc_write);
    flush_d = flush_q + CNT_W'(ifid_flush);
  end

  // counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

  // a branch resolving while EX requests mul/div cannot happen
  a_no_branch_with_md : assert property (
    @(posedge clk) disable iff (!rst_n)
    !((state_q == IDLE) && !kill && branch_taken && idex_md_req)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed vectors checked against a cycle model.
// Counter expectations follow `HAZARD_PERF_CNT_EN.
module tb_hazard_controller;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ifid_rs1, ifid_rs2, idex_rd;
  logic        ifid_use_rs1, ifid_use_rs2;
  logic        idex_memrd, idex_md_req;
  logic        branch_taken, kill;
  logic        pc_write, ifid_write, idex_write;
  logic        ifid_flush, idex_flush, exmem_bubble;
  logic        md_start, md_done, md_abort, md_busy;
  logic [31:0] stall_cycles, flush_count;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_controller #(.MD_LATENCY(LAT), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .ifid_use_rs1(ifid_use_rs1), .ifid_use_rs2(ifid_use_rs2),
    .idex_memrd(idex_memrd), .idex_rd(idex_rd),
    .idex_md_req(idex_md_req), .branch_taken(branch_taken),
    .kill(kill), .pc_write(pc_write),
    .ifid_write(ifid_write), .idex_write(idex_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_bubble(exmem_bubble), .md_start(md_start),
    .md_done(md_done), .md_abort(md_abort), .md_busy(md_busy),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic a, input logic e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b @%0t", nm, a, e, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d @%0t", nm, a, e, $time);
    end
  endtask

  // model: md_t counts cycles since md_start (-1 = no operation)
  int          md_t = -1, n_t = -1;
  logic [31:0] stall_m = 0, flush_m = 0, n_stall = 0, n_flush = 0;

  always @(negedge clk) begin
    logic e_pc, e_ifw, e_idw, e_iff, e_idf, e_bub;
    logic e_st, e_dn, e_ab, e_bz, lu;
    logic [31:0] e_sc, e_fc;
    e_pc = 1; e_ifw = 1; e_idw = 1; e_iff = 0; e_idf = 0;
    e_bub = 0; e_st = 0; e_dn = 0; e_ab = 0; e_bz = 0;
    n_t = md_t;
    lu = idex_memrd && idex_rd != 0 &&
         ((idex_rd == ifid_rs1 && ifid_use_rs1) ||
          (idex_rd == ifid_rs2 && ifid_use_rs2));
    if (!rst_n) begin
      n_t = -1; n_stall = 0; n_flush = 0;
    end else begin
      e_bz = (md_t >= 1 && md_t <= LAT);
      if (kill) begin
        e_iff = 1; e_idf = 1; e_bub = 1;
        e_ab = (md_t >= 1);
        n_t = -1;
      end else if (md_t >= 1 && md_t <= LAT) begin
        e_pc = 0; e_ifw = 0; e_idw = 0; e_bub = 1;
        n_t = md_t + 1;
      end else if (md_t == LAT + 1) begin
        e_dn = 1; n_t = -1;
      end else if (idex_md_req) begin
        e_st = 1; e_pc = 0; e_ifw = 0; e_idw = 0; e_bub = 1;
        n_t = 1;
      end else if (branch_taken) begin
        e_iff = 1; e_idf = 1;
      end else if (lu) begin
        e_pc = 0; e_ifw = 0; e_idf = 1;
      end
      n_stall = stall_m + (e_pc ? 0 : 1);
      n_flush = flush_m + (e_iff ? 1 : 0);
    end
`ifdef HAZARD_PERF_CNT_EN
    e_sc = rst_n ? stall_m : 0;
    e_fc = rst_n ? flush_m : 0;
`else
    e_sc = 0;
    e_fc = 0;
`endif
    chk("m_pc_write", pc_write, e_pc);
    chk("m_ifid_write", ifid_write, e_ifw);
    chk("m_idex_write", idex_write, e_idw);
    chk("m_ifid_flush", ifid_flush, e_iff);
    chk("m_idex_flush", idex_flush, e_idf);
    chk("m_exmem_bubble", exmem_bubble, e_bub);
    chk("m_md_start", md_start, e_st);
    chk("m_md_done", md_done, e_dn);
    chk("m_md_abort", md_abort, e_ab);
    chk("m_md_busy", md_busy, e_bz);
    chk32("m_stall_cycles", stall_cycles, e_sc);
    chk32("m_flush_count", flush_count, e_fc);
  end

  always @(posedge clk) begin
    md_t    <= n_t;
    stall_m <= n_stall;
    flush_m <= n_flush;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ifid_rs1 = 0; ifid_rs2 = 0; idex_rd = 0;
    ifid_use_rs1 = 0; ifid_use_rs2 = 0;
    idex_memrd = 0; idex_md_req = 0;
    branch_taken = 0; kill = 0;
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    clr();
    rst_n = 0;
    idex_md_req = 1;
    @(negedge clk);
    chk("rst_pc", pc_write, 1'b1);
    chk("rst_ifw", ifid_write, 1'b1);
    chk("rst_start", md_start, 1'b0);
    chk("rst_bubble", exmem_bubble, 1'b0);
    cyc(); cyc();
    rst_n = 1; clr();
    @(negedge clk);
    chk("idle_pc", pc_write, 1'b1);

    // load-use on rs2
    cyc();
    idex_memrd = 1; idex_rd = 5; ifid_rs2 = 5; ifid_use_rs2 = 1;
    @(negedge clk);
    chk("lu_pc", pc_write, 1'b0);
    chk("lu_ifw", ifid_write, 1'b0);
    chk("lu_idf", idex_flush, 1'b1);
    chk("lu_idw", idex_write, 1'b1);
    cyc(); clr();
    @(negedge clk);
    chk("after_lu_pc", pc_write, 1'b1);

    // x0 load is never a hazard
    cyc();
    idex_memrd = 1; idex_rd = 0; ifid_rs1 = 0; ifid_use_rs1 = 1;
    @(negedge clk);
    chk("x0_pc", pc_write, 1'b1);
    chk("x0_idf", idex_flush, 1'b0);

    // matching register not actually read
    cyc();
    idex_rd = 7; ifid_rs1 = 7; ifid_use_rs1 = 0;
    ifid_rs2 = 3; ifid_use_rs2 = 1;
    @(negedge clk);
    chk("nouse_pc", pc_write, 1'b1);

    // full mul/div sequence
    cyc(); clr();
    idex_md_req = 1;
    for (int i = 0; i <= LAT + 1; i++) begin
      @(negedge clk);
      if (i == 0) chk("md_t0_start", md_start, 1'b1);
      chk("md_pc", pc_write, (i <= LAT) ? 1'b0 : 1'b1);
      if (i == LAT + 1) chk("md_done_t9", md_done, 1'b1);
      cyc();
    end
    clr();
    @(negedge clk);
    chk("md_t10_busy", md_busy, 1'b0);
    chk("md_t10_start", md_start, 1'b0);

    // kill at T4 of a mul/div
    cyc();
    idex_md_req = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cyc();
    end
    kill = 1;
    @(negedge clk);
    chk("k_abort", md_abort, 1'b1);
    chk("k_iff", ifid_flush, 1'b1);
    chk("k_pc", pc_write, 1'b1);
    cyc(); clr();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("k_no_done", md_done, 1'b0);
      chk("k_idle", md_busy, 1'b0);
      cyc();
    end

    // branch beats load-use
    branch_taken = 1;
    idex_memrd = 1; idex_rd = 5; ifid_rs2 = 5; ifid_use_rs2 = 1;
    @(negedge clk);
    chk("br_iff", ifid_flush, 1'b1);
    chk("br_idf", idex_flush, 1'b1);
    chk("br_pc", pc_write, 1'b1);
    chk("br_ifw", ifid_write, 1'b1);
    cyc(); clr();

    // kill in idle suppresses md_start
    kill = 1; idex_md_req = 1;
    @(negedge clk);
    chk("ki_start", md_start, 1'b0);
    chk("ki_abort", md_abort, 1'b0);
    cyc(); clr();
    @(negedge clk);
    chk("ki_busy", md_busy, 1'b0);
    cyc();

    // kill in DONE aborts instead of completing
    idex_md_req = 1;
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      cyc();
    end
    kill = 1;
    @(negedge clk);
    chk("kd_abort", md_abort, 1'b1);
    chk("kd_done", md_done, 1'b0);
    cyc(); clr();
    @(negedge clk);
    chk("kd_busy", md_busy, 1'b0);
    cyc();

    // reset in the middle of BUSY
    idex_md_req = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cyc();
    end
    rst_n = 0;
    @(negedge clk);
    chk("rs_busy", md_busy, 1'b0);
    chk("rs_pc", pc_write, 1'b1);
    chk32("rs_stall", stall_cycles, 32'd0);
    chk32("rs_flush", flush_count, 32'd0);
    cyc();
    rst_n = 1; clr();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rs_no_done", md_done, 1'b0);
      chk("rs_no_abort", md_abort, 1'b0);
      cyc();
    end

    // one md op plus one branch from cleared counters
    idex_md_req = 1;
    repeat (LAT + 2) cyc();
    clr();
    branch_taken = 1;
    cyc(); clr();
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    chk32("perf_stall", stall_cycles, 32'd9);
    chk32("perf_flush", flush_count, 32'd1);
`else
    chk32("perf_stall", stall_cycles, 32'd0);
    chk32("perf_flush", flush_count, 32'd0);
`endif
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
